// File: rtl/tester_status_display_pkg.sv
// Shared types and constants for the tester status display: BCD digit type,
// digit count and active-high 7-segment patterns (bit0 = a, bit6 = g).
package tester_status_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/tester_status_display_if.sv
// Strobe inputs from the tester core and the board-level display outputs.
interface tester_status_display_if
    import tester_status_display_pkg::*;
#(
    parameter int ERR_WIDTH = 10
);
    logic                  inc_pass;
    logic                  inc_err;
    logic                  clr;
    logic [6:0]            seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic [ERR_WIDTH-1:0]  err_leds;
    logic                  pass_wrapped;

    modport master (
        output inc_pass, inc_err, clr,
        input  seg, dp, dig_sel, err_leds, pass_wrapped
    );

    modport slave (
        input  inc_pass, inc_err, clr,
        output seg, dp, dig_sel, err_leds, pass_wrapped
    );
endinterface

// File: rtl/tester_status_display_bcd_to_7seg.sv
// Combinational BCD digit to active-high segment decoder with blanking.
module tester_status_display_bcd_to_7seg
    import tester_status_display_pkg::*;
(
    input  bcd_t       i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/tester_status_display.sv
// Pass/error status display: BCD pass counter on a scanned 4-digit 7-segment
// display with leading-zero blanking, saturating error counter on an LED bar.
module tester_status_display
    import tester_status_display_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 14,
    parameter int ERR_WIDTH      = 10,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    tester_status_display_if.slave  bus
);
    localparam logic POL = SEG_ACTIVE_LOW;

    logic                          r_inc_pass_d;
    bcd_t [NUM_DIGITS-1:0]         r_digits;
    logic                          r_pass_wrapped;
    logic [ERR_WIDTH-1:0]          r_err_cnt;
    logic [SCAN_DIV_BITS-1:0]      r_presc;
    logic [1:0]                    r_dig_idx;
    logic [6:0]                    r_seg;
    logic                          r_dp;
    logic [NUM_DIGITS-1:0]         r_dig_sel;

    logic                          w_pass_inc;
    logic [NUM_DIGITS:0]           w_carry;
    bcd_t [NUM_DIGITS-1:0]         w_digit_next;
    logic [NUM_DIGITS-1:0]         w_blank;
    logic [6:0]                    w_seg;
    logic [NUM_DIGITS-1:0]         w_dig_onehot;
    logic                          w_dp;

    assign w_pass_inc = bus.inc_pass & ~r_inc_pass_d;
    assign w_carry[0] = w_pass_inc;

    // Ripple-carry BCD increment plus leading-zero blanking chain from the MSD down.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_digit_next[gi] = !w_carry[gi]          ? r_digits[gi] :
                                      (r_digits[gi] == 4'd9) ? 4'd0 :
                                                               r_digits[gi] + 4'd1;
            assign w_carry[gi+1] = w_carry[gi] & (r_digits[gi] == 4'd9);

            if (gi == 0) begin : g_lsd
                assign w_blank[gi] = 1'b0;
            end else if (gi == NUM_DIGITS - 1) begin : g_msd
                assign w_blank[gi] = (r_digits[gi] == 4'd0);
            end else begin : g_mid
                assign w_blank[gi] = w_blank[gi+1] & (r_digits[gi] == 4'd0);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inc_pass_d   <= 1'b0;
            r_digits       <= '0;
            r_pass_wrapped <= 1'b0;
            r_err_cnt      <= '0;
        end else begin
            r_inc_pass_d <= bus.inc_pass;
            if (bus.clr) begin
                r_digits       <= '0;
                r_pass_wrapped <= 1'b0;
                r_err_cnt      <= '0;
            end else begin
                r_digits <= w_digit_next;
                if (w_carry[NUM_DIGITS]) begin
                    r_pass_wrapped <= 1'b1;
                end
                if (bus.inc_err && (r_err_cnt != {ERR_WIDTH{1'b1}})) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_dig_idx <= 2'd0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (&r_presc) begin
                r_dig_idx <= r_dig_idx + 2'd1;
            end
        end
    end

    tester_status_display_bcd_to_7seg u_bcd_to_7seg (
        .i_digit (r_digits[r_dig_idx]),
        .i_blank (w_blank[r_dig_idx]),
        .o_seg   (w_seg)
    );

    assign w_dig_onehot = NUM_DIGITS'(1) << r_dig_idx;
    assign w_dp         = (r_dig_idx == 2'd0) & r_pass_wrapped;

    // Segment, dp and select share one register stage so they switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg     <= {7{POL}};
            r_dp      <= POL;
            r_dig_sel <= {NUM_DIGITS{POL}};
        end else begin
            r_seg     <= w_seg ^ {7{POL}};
            r_dp      <= w_dp ^ POL;
            r_dig_sel <= w_dig_onehot ^ {NUM_DIGITS{POL}};
        end
    end

    assign bus.seg          = r_seg;
    assign bus.dp           = r_dp;
    assign bus.dig_sel      = r_dig_sel;
    assign bus.err_leds     = r_err_cnt;
    assign bus.pass_wrapped = r_pass_wrapped;

endmodule

// File: tb/tb_tester_status_display.sv
// Randomized, model-checked bench for tester_status_display (fast scan, active-low board).
module tb_tester_status_display;

    localparam int EW      = 10;
    localparam int ERR_MAX = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tester_status_display_if #(.ERR_WIDTH(EW)) bus ();

    tester_status_display #(
        .SCAN_DIV_BITS  (2),
        .ERR_WIDTH      (EW),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integers following the counting rules.
    int   m_count   = 0;
    int   m_err     = 0;
    bit   m_wrapped = 0;
    bit   m_prev    = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] exp_seg(int slot);
        int p;
        p = 10 ** slot;
        if (slot > 0 && m_count < p) return 7'h00;
        return seg_tab[(m_count / p) % 10];
    endfunction

    task automatic model_reset();
        m_count = 0; m_err = 0; m_wrapped = 0; m_prev = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (bus.clr) begin
            m_count = 0; m_err = 0; m_wrapped = 0;
        end else begin
            if (bus.inc_pass && !m_prev) begin
                m_count = m_count + 1;
                if (m_count == 10000) begin
                    m_count = 0; m_wrapped = 1;
                end
            end
            if (bus.inc_err && m_err < ERR_MAX) m_err = m_err + 1;
        end
        m_prev = bus.inc_pass;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.inc_pass = 0; bus.inc_err = 0; bus.clr = 0;
    endtask

    task automatic do_clr();
        idle_inputs(); bus.clr = 1; tick(); bus.clr = 0; tick();
    endtask

    task automatic pass_edge(int high_cycles);
        bus.inc_pass = 1;
        repeat (high_cycles) tick();
        bus.inc_pass = 0;
        tick();
    endtask

    // Watch the display for several full scans; every cycle the visible slot must show the model value.
    task automatic scan_check(string name);
        int slot;
        idle_inputs();
        repeat (2) tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            slot = -1;
            for (int i = 0; i < 4; i++)
                if (bus.dig_sel == ~(4'b0001 << i)) slot = i;
            n_checks++;
            if (slot < 0) begin
                $display("FAIL %s dig_sel: got %b, required one active-low digit", name, bus.dig_sel);
            end else if (bus.seg !== ~exp_seg(slot) || bus.dp !== ~(slot == 0 && m_wrapped)) begin
                $display("FAIL %s slot%0d: seg=%h dp=%b, required seg=%h dp=%b (count %0d)",
                         name, slot, bus.seg, bus.dp, ~exp_seg(slot), !(slot == 0 && m_wrapped), m_count);
            end else begin
                n_pass++;
            end
        end
        $display("scan %s: count=%0d wrapped=%0d", name, m_count, m_wrapped);
    endtask

    task automatic check_counters(string name);
        n_checks++;
        if (bus.err_leds !== EW'(m_err) || bus.pass_wrapped !== m_wrapped) begin
            $display("FAIL %s: err_leds=%0d wrapped=%b, required err_leds=%0d wrapped=%b",
                     name, bus.err_leds, bus.pass_wrapped, m_err, m_wrapped);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1;
        #1;
        n_checks++;
        if (bus.seg !== 7'h7F || bus.dig_sel !== 4'hF || bus.dp !== 1'b1 ||
            bus.err_leds !== '0 || bus.pass_wrapped !== 1'b0) begin
            $display("FAIL reset_outputs: seg=%h dig_sel=%h dp=%b err=%0d wrapped=%b, required 7f f 1 0 0",
                     bus.seg, bus.dig_sel, bus.dp, bus.err_leds, bus.pass_wrapped);
        end else begin
            n_pass++;
        end
        idle_inputs();
        @(negedge clk);
        rst = 0;
        model_reset();
        tick();
        n_checks++;
        if (bus.dig_sel !== 4'b1110 || bus.seg !== ~7'h3F) begin
            $display("FAIL reset_restart: dig_sel=%b seg=%h, required 1110 %h", bus.dig_sel, bus.seg, ~7'h3F);
        end else begin
            n_pass++;
        end
        $display("reset: outputs inactive, scan restarted at digit 0");
    endtask

    task automatic test_pass_edges();
        do_clr();
        for (int i = 0; i < 3; i++) pass_edge(2);
        scan_check("pass_edges_0003");
    endtask

    task automatic test_scan_timing();
        logic [3:0] prev_sel, a;
        int last_change;
        idle_inputs();
        tick();
        prev_sel    = bus.dig_sel;
        last_change = -1;
        for (int c = 0; c < 32; c++) begin
            tick();
            if (bus.dig_sel !== prev_sel) begin
                a = ~prev_sel;
                n_checks++;
                if (bus.dig_sel !== ~{a[2:0], a[3]} || (last_change >= 0 && c - last_change != 4)) begin
                    $display("FAIL scan_timing: sel %b->%b after %0d clks, required %b after 4",
                             prev_sel, bus.dig_sel, c - last_change, ~{a[2:0], a[3]});
                end else begin
                    n_pass++;
                end
                last_change = c;
                prev_sel    = bus.dig_sel;
            end
        end
        n_checks++;
        if (last_change < 0) $display("FAIL scan_timing: dig_sel=%b never changed, required rotation", prev_sel);
        else n_pass++;
        $display("scan_timing: rotation observed");
    endtask

    task automatic test_err_saturation();
        do_clr();
        bus.inc_err = 1;
        for (int i = 0; i < 1030; i++) begin
            tick();
            check_counters("err_climb");
        end
        bus.inc_err = 0;
        tick();
        n_checks++;
        if (bus.err_leds !== 10'd1023) $display("FAIL err_saturate: err_leds=%0d, required 1023", bus.err_leds);
        else n_pass++;
        $display("err_saturation: err_leds=%0d", bus.err_leds);
    endtask

    task automatic test_pass_wrap();
        do_clr();
        for (int i = 0; i < 9999; i++) pass_edge(1);
        check_counters("pre_wrap");
        scan_check("count_9999");
        pass_edge(1);
        check_counters("wrap");
        scan_check("wrap_0000");
    endtask

    task automatic test_clr_priority();
        do_clr();
        for (int i = 0; i < 42; i++) pass_edge(1);
        scan_check("count_0042");
        m_wrapped = 1'b0;
        bus.clr = 1; bus.inc_pass = 1;
        tick();
        bus.clr = 0;
        tick();
        check_counters("clr_priority");
        scan_check("after_clr_0000");
        pass_edge(3);
        scan_check("after_clr_0001");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.inc_pass = 1'($urandom_range(0, 1));
            bus.inc_err  = 1'($urandom_range(0, 1));
            bus.clr      = ($urandom_range(0, 39) == 0);
            tick();
            check_counters("random");
            if (i % 100 == 99) scan_check("random");
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        test_reset();
        test_pass_edges();
        test_scan_timing();
        test_err_saturation();
        test_pass_wrap();
        test_clr_priority();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tester_status_display.md
Name: tester_status_display

Overview:
Downstream consumer of the DRAM memory tester's status strobes. It keeps a 4-digit BCD pass counter (0000-9999) and a saturating binary error counter. It drives a time-multiplexed 4-digit 7-segment display for passes and a 10-LED bar for errors. It sits between the tester core and the board-level display pins.

Parameters:
SCAN_DIV_BITS, 14, width of the clk prescaler; the digit advances once every 2^SCAN_DIV_BITS clocks.
ERR_WIDTH, 10, width of the error counter and of the LED bar.
SEG_ACTIVE_LOW, 1, 1 means segment and digit outputs are inverted (common-anode board).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
inc_pass  in  1  pass strobe from the tester; may stay high for several cycles
inc_err  in  1  error strobe; each clk cycle it is high counts one error
clr  in  1  synchronous clear of both counters and of the wrap flag
seg  out  7  segments a..g (bit0=a), polarity set by SEG_ACTIVE_LOW
dp  out  1  decimal point, same polarity as seg
dig_sel  out  4  one-hot digit enable (bit0 = least significant digit), same polarity as seg
err_leds  out  ERR_WIDTH  error count in binary, active-high
pass_wrapped  out  1  sticky; set when the pass count wraps from 9999 to 0000

Behaviour:
- Reset (async, rst=1):
  - All counters, the wrap flag, the prescaler and the digit index go to 0.
  - Outputs go inactive: seg/dp/dig_sel all-off, which is all-ones when SEG_ACTIVE_LOW=1; err_leds=0; pass_wrapped=0.
- Pass edge detect:
  - inc_pass is registered into inc_pass_d.
  - The increment condition is inc_pass & ~inc_pass_d.
  - Exactly one increment per rising edge, regardless of pulse length.
  - The count updates on the clock after the edge is detected, giving 1-cycle latency from the first high sample.
- BCD increment:
  - Digit 0 increments; a digit at 9 rolls to 0 and carries into the next digit.
  - 9999 + 1 gives 0000 and sets pass_wrapped in the same cycle.
  - Digits never hold values 10-15.
- Error counter:
  - Increments by 1 on every cycle with inc_err=1.
  - Saturates at 2^ERR_WIDTH-1 (1023 at the default width); it never wraps.
  - err_leds is the registered counter value directly.
- clr has priority over any simultaneous increment: counters and pass_wrapped go to 0, and the edge-detect register still samples inc_pass.
- Prescaler:
  - SCAN_DIV_BITS-bit free-running up-counter.
  - On the cycle it equals all-ones, the 2-bit digit index increments, wrapping 3 to 0.
- Digit mux:
  - Selects BCD digit[index] and produces the segment pattern plus the one-hot select of index.
  - seg, dp and dig_sel are registered together, so they change in the same cycle (no ghosting skew).
  - Output latency is 1 clk after the index changes.
- Leading-zero blanking:
  - Digit 3 is blank if it is 0.
  - Digit 2 is blank if digits 3 and 2 are both 0.
  - Digit 1 is blank if digits 3, 2 and 1 are all 0.
  - Digit 0 is always shown.
  - A blank digit outputs all segments off, but dig_sel stays active for its slot.
- dp is lit only in the digit-0 slot while pass_wrapped=1.
- Segment encoding: standard 0-9, with a=top and g=middle.
- Reset mid-scan: the display restarts at digit 0 with the prescaler at 0.

Decomposition:
- Shared package holds:
  - the 7-bit segment constants for 0-9 and for BLANK;
  - the digit-count constant 4;
  - the BCD digit typedef (4 bits).
- One natural sub-module: bcd_to_7seg. It is purely combinational, taking a 4-bit digit and a blank input and returning 7 active-high segments. Polarity inversion is done in the parent.

Test Plan:
- Reset check: assert rst mid-run -> immediately seg=7'h7F, dig_sel=4'hF, dp=1 (SEG_ACTIVE_LOW=1); err_leds=0; pass_wrapped=0.
- Pass edges: 3 pulses of inc_pass, each 2 cycles wide -> BCD count 0003; scanning shows digit 0 as pattern "3" and digits 1-3 blank.
- Pass wrap: 9999 rising edges -> count 9999; one more edge -> 0000, pass_wrapped=1, dp lit only in the digit-0 slot.
- Error saturation: inc_err high for 1030 consecutive cycles -> err_leds climbs to 1023 and holds; no wrap.
- clr priority: clr and an inc_pass rising edge on the same cycle with count 0042 -> count 0000, pass_wrapped=0; a following edge gives 0001.
- Scan timing with SCAN_DIV_BITS=2: dig_sel cycles 0001, 0010, 0100, 1000 (before inversion) every 4 clks, and seg updates in the same cycle as dig_sel.
